vadd_engine: RTL and testbench

- Compute stage directly downstream of the host CSR block.
- Consumes launch, length, a_addr, b_addr and c_addr from the CSR block.
- Computes c[i] = a[i] + b[i] for i in 0..length-1 over the shared memory interface, one element at a time.
- Returns a finish pulse and the elapsed cycle count to the CSR block, which stores them in its status and cycle-counter registers.

---
 rtl/vadd_engine_if.sv | 30 +++
 rtl/vadd_engine.sv | 141 ++++++++++++++
 tb/tb_vadd_engine.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vadd_engine_if.sv
// Single-beat memory bus between vadd_engine (master) and the shared memory (slave).
interface vadd_engine_if #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64
);
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]  mem_req_len;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_wr_valid;
  logic                     mem_wr_ready;
  logic [MEM_DATA_BITS-1:0] mem_wr_bits;
  logic                     mem_rd_valid;
  logic                     mem_rd_ready;
  logic [MEM_DATA_BITS-1:0] mem_rd_bits;

  modport master (
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_wr_valid, mem_wr_bits, mem_rd_ready,
    input  mem_req_ready, mem_wr_ready, mem_rd_valid, mem_rd_bits
  );

  modport slave (
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
    output mem_req_ready, mem_wr_ready, mem_rd_valid, mem_rd_bits
  );
endinterface

// File: rtl/vadd_engine.sv
// Element-wise vector add engine: c[i] = a[i] + b[i], one element at a time.
// Define VADD_ENGINE_SATURATE_EN to clamp overflowing sums to all ones instead of wrapping.
module vadd_engine #(
  parameter int HOST_DATA_BITS = 32,
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  output logic                      finish,
  output logic                      event_counter_valid,
  output logic [HOST_DATA_BITS-1:0] event_counter_value,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [HOST_DATA_BITS-1:0] a_addr,
  input  logic [HOST_DATA_BITS-1:0] b_addr,
  input  logic [HOST_DATA_BITS-1:0] c_addr,
  vadd_engine_if.master             mem
);
  localparam int STRIDE = MEM_DATA_BITS / 8;

  typedef enum logic [2:0] {
    IDLE, RD_REQ_A, RD_DAT_A, RD_REQ_B, RD_DAT_B, WR_REQ, WR_DAT, DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [HOST_DATA_BITS-1:0] index_q, index_d;
  logic [HOST_DATA_BITS-1:0] counter_q, counter_d;
  logic [MEM_DATA_BITS-1:0]  a_q, a_d;
  logic [MEM_DATA_BITS-1:0]  b_q, b_d;
  logic [HOST_DATA_BITS-1:0] index_inc;
  logic [MEM_ADDR_BITS-1:0]  offset;
  logic [MEM_DATA_BITS-1:0]  sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      index_q   <= '0;
      counter_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      counter_q <= counter_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign index_inc = index_q + HOST_DATA_BITS'(1);
  assign offset    = MEM_ADDR_BITS'(index_q) * MEM_ADDR_BITS'(STRIDE);

`ifdef VADD_ENGINE_SATURATE_EN
  logic [MEM_DATA_BITS:0] sum_full;
  assign sum_full = {1'b0, a_q} + {1'b0, b_q};
  assign sum      = sum_full[MEM_DATA_BITS] ? '1 : sum_full[MEM_DATA_BITS-1:0];
`else
  assign sum = a_q + b_q;
`endif

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    counter_d = counter_q;
    a_d       = a_q;
    b_d       = b_q;

    mem.mem_req_valid   = 1'b0;
    mem.mem_req_opcode  = 1'b0;
    mem.mem_req_len     = MEM_LEN_BITS'(0);
    mem.mem_req_addr    = '0;
    mem.mem_wr_valid    = 1'b0;
    mem.mem_wr_bits     = '0;
    mem.mem_rd_ready    = 1'b0;
    finish              = 1'b0;
    event_counter_valid = 1'b0;
    event_counter_value = '0;

    // Every busy cycle counts, so stalls on any channel show up in the reported total.
    if (state_q != IDLE && state_q != DONE) begin
      counter_d = counter_q + HOST_DATA_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          index_d   = '0;
          counter_d = '0;
          state_d   = (length == '0) ? DONE : RD_REQ_A;
        end
      end
      RD_REQ_A: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = MEM_ADDR_BITS'(a_addr) + offset;
        if (mem.mem_req_ready) state_d = RD_DAT_A;
      end
      RD_DAT_A: begin
        mem.mem_rd_ready = 1'b1;
        if (mem.mem_rd_valid) begin
          a_d     = mem.mem_rd_bits;
          state_d = RD_REQ_B;
        end
      end
      RD_REQ_B: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = MEM_ADDR_BITS'(b_addr) + offset;
        if (mem.mem_req_ready) state_d = RD_DAT_B;
      end
      RD_DAT_B: begin
        mem.mem_rd_ready = 1'b1;
        if (mem.mem_rd_valid) begin
          b_d     = mem.mem_rd_bits;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        mem.mem_req_valid  = 1'b1;
        mem.mem_req_opcode = 1'b1;
        mem.mem_req_addr   = MEM_ADDR_BITS'(c_addr) + offset;
        if (mem.mem_req_ready) state_d = WR_DAT;
      end
      WR_DAT: begin
        mem.mem_wr_valid = 1'b1;
        mem.mem_wr_bits  = sum;
        if (mem.mem_wr_ready) begin
          index_d = index_inc;
          state_d = (index_inc == length) ? DONE : RD_REQ_A;
        end
      end
      DONE: begin
        finish              = 1'b1;
        event_counter_valid = 1'b1;
        event_counter_value = counter_q;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vadd_engine.sv
// Scoreboard bench for vadd_engine: a stallable single-beat memory model feeds operands,
// expected writes are queued per test and popped as the engine writes them.
`timescale 1ns/1ps
module tb_vadd_engine;
  localparam int HDB = 32;
  localparam int MLB = 8;
  localparam int MAB = 64;
  localparam int MDB = 64;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           launch = 1'b0;
  logic           finish;
  logic           event_counter_valid;
  logic [HDB-1:0] event_counter_value;
  logic [HDB-1:0] length = '0;
  logic [HDB-1:0] a_addr = '0;
  logic [HDB-1:0] b_addr = '0;
  logic [HDB-1:0] c_addr = '0;

  vadd_engine_if #(.MEM_LEN_BITS(MLB), .MEM_ADDR_BITS(MAB), .MEM_DATA_BITS(MDB)) mem_if ();

  vadd_engine #(
    .HOST_DATA_BITS(HDB), .MEM_LEN_BITS(MLB), .MEM_ADDR_BITS(MAB), .MEM_DATA_BITS(MDB)
  ) dut (
    .clock(clock), .reset(reset), .launch(launch), .finish(finish),
    .event_counter_valid(event_counter_valid), .event_counter_value(event_counter_value),
    .length(length), .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .mem(mem_if)
  );

  always #5 clock = ~clock;

  wr_exp_t     exp_q[$];
  logic [63:0] mem_model [logic [63:0]];
  int          req_delay = 0, wr_delay = 0, rd_delay = 0;
  bit          wr_block = 1'b0;
  int          req_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [63:0] rd_addr_pend = '0, wr_addr_pend = '0;
  int          checks = 0, failures = 0;
  int          writes_done = 0, req_valid_cycles = 0, finish_pulses = 0;

  logic [63:0] av [4];
  logic [63:0] bv [4];
  logic [63:0] sv [4];

  // Memory responder: handshake inputs change just after the rising edge.
  initial begin : mem_driver
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_wr_ready  = 1'b0;
    mem_if.mem_rd_valid  = 1'b0;
    mem_if.mem_rd_bits   = '0;
    forever begin
      @(posedge clock);
      #1;
      req_cnt = mem_if.mem_req_valid ? req_cnt + 1 : 0;
      wr_cnt  = mem_if.mem_wr_valid  ? wr_cnt + 1  : 0;
      rd_cnt  = mem_if.mem_rd_ready  ? rd_cnt + 1  : 0;
      mem_if.mem_req_ready = mem_if.mem_req_valid && (req_cnt > req_delay);
      mem_if.mem_wr_ready  = mem_if.mem_wr_valid && !wr_block && (wr_cnt > wr_delay);
      mem_if.mem_rd_valid  = mem_if.mem_rd_ready && (rd_cnt > rd_delay);
      mem_if.mem_rd_bits   = mem_model.exists(rd_addr_pend) ? mem_model[rd_addr_pend] : '0;
    end
  end

  // Monitor: samples on the falling edge, scores writes and checks stall stability.
  initial begin : monitor
    wr_exp_t     e;
    bit          req_stall, wr_stall;
    logic [63:0] req_addr_snap, wr_bits_snap;
    logic        req_op_snap, prev_finish;
    req_stall = 0; wr_stall = 0; prev_finish = 0;
    req_addr_snap = '0; wr_bits_snap = '0; req_op_snap = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        req_stall = 0; wr_stall = 0; prev_finish = 0;
      end else begin
        if (mem_if.mem_req_valid) req_valid_cycles++;
        if (req_stall) begin
          checks++;
          if (mem_if.mem_req_valid !== 1'b1 || mem_if.mem_req_addr !== req_addr_snap ||
              mem_if.mem_req_opcode !== req_op_snap) begin
            failures++;
            $display("[TB] FAIL req_stable got v=%b a=%h op=%b want v=1 a=%h op=%b",
                     mem_if.mem_req_valid, mem_if.mem_req_addr, mem_if.mem_req_opcode,
                     req_addr_snap, req_op_snap);
          end
        end
        req_stall     = mem_if.mem_req_valid && !mem_if.mem_req_ready;
        req_addr_snap = mem_if.mem_req_addr;
        req_op_snap   = mem_if.mem_req_opcode;
        if (wr_stall) begin
          checks++;
          if (mem_if.mem_wr_valid !== 1'b1 || mem_if.mem_wr_bits !== wr_bits_snap) begin
            failures++;
            $display("[TB] FAIL wr_stable got v=%b d=%h want v=1 d=%h",
                     mem_if.mem_wr_valid, mem_if.mem_wr_bits, wr_bits_snap);
          end
        end
        wr_stall     = mem_if.mem_wr_valid && !mem_if.mem_wr_ready;
        wr_bits_snap = mem_if.mem_wr_bits;

        if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
          if (mem_if.mem_req_opcode) wr_addr_pend = mem_if.mem_req_addr;
          else                       rd_addr_pend = mem_if.mem_req_addr;
        end
        if (mem_if.mem_wr_valid && mem_if.mem_wr_ready) begin
          mem_model[wr_addr_pend] = mem_if.mem_wr_bits;
          writes_done++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_write got a=%h d=%h want none",
                     wr_addr_pend, mem_if.mem_wr_bits);
          end else begin
            e = exp_q.pop_front();
            if (wr_addr_pend !== e.addr || mem_if.mem_wr_bits !== e.data) begin
              failures++;
              $display("[TB] FAIL write got a=%h d=%h want a=%h d=%h",
                       wr_addr_pend, mem_if.mem_wr_bits, e.addr, e.data);
            end
          end
        end

        if (finish) begin
          finish_pulses++;
          checks++;
          if (prev_finish !== 1'b0) begin
            failures++;
            $display("[TB] FAIL finish_width got consecutive finish cycles want 1");
          end
        end
        prev_finish = finish;
        checks++;
        if (finish !== event_counter_valid ||
            (!event_counter_valid && event_counter_value !== '0)) begin
          failures++;
          $display("[TB] FAIL counter_strobe got fin=%b v=%b val=%0d want fin=v, val=0 when idle",
                   finish, event_counter_valid, event_counter_value);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog got no completion want finished bench");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] model_sum(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef VADD_ENGINE_SATURATE_EN
    return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
`else
    return s[63:0];
`endif
  endfunction

  task automatic do_run(input logic [31:0] len, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input int budget, output bit timed_out,
                        output logic [31:0] cnt, output int cycles);
    @(negedge clock);
    length = len; a_addr = a; b_addr = b; c_addr = c; launch = 1'b1;
    timed_out = 1'b1; cnt = '0; cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      cycles++;
      if (finish) begin
        cnt = event_counter_value;
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clock);
    #1 launch = 1'b0;
  endtask

  task automatic load_basic(input int n);
    for (int i = 0; i < 4; i++) begin
      mem_model[64'h100 + 64'(8 * i)] = av[i];
      mem_model[64'h200 + 64'(8 * i)] = bv[i];
    end
    for (int i = 0; i < n; i++) exp_q.push_back({64'h300 + 64'(8 * i), sv[i]});
  endtask

  task automatic check_run(input string name, input bit timed_out, input logic [31:0] cnt,
                           input int cycles, input logic [31:0] want_cnt);
    checks++;
    if (timed_out || cnt !== want_cnt || cycles != int'(want_cnt) + 1) begin
      failures++;
      $display("[TB] FAIL %s got timeout=%b count=%0d cycles=%0d want timeout=0 count=%0d cycles=%0d",
               name, timed_out, cnt, cycles, want_cnt, want_cnt + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_writes got pending=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [255:0] outs;
    #2;
    outs = {finish, event_counter_valid, event_counter_value, mem_if.mem_req_valid,
            mem_if.mem_req_opcode, mem_if.mem_req_len, mem_if.mem_req_addr,
            mem_if.mem_wr_valid, mem_if.mem_wr_bits, mem_if.mem_rd_ready};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got %h want 0", outs);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (mem_if.mem_req_valid !== 1'b0 || finish !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_quiet got req=%b fin=%b want 0 0", mem_if.mem_req_valid, finish);
    end
  endtask

  task automatic test_zero_length();
    bit t; logic [31:0] cnt; int cyc, req0, fin0;
    req0 = req_valid_cycles; fin0 = finish_pulses;
    do_run(32'd0, 32'h100, 32'h200, 32'h300, 20, t, cnt, cyc);
    check_run("zero_length", t, cnt, cyc, 32'd0);
    repeat (3) @(negedge clock);
    checks++;
    if (req_valid_cycles != req0 || finish_pulses != fin0 + 1) begin
      failures++;
      $display("[TB] FAIL zero_length_bus got req_cycles=%0d pulses=%0d want 0 1",
               req_valid_cycles - req0, finish_pulses - fin0);
    end
  endtask

  task automatic test_basic();
    bit t; logic [31:0] cnt; int cyc;
    load_basic(4);
    do_run(32'd4, 32'h100, 32'h200, 32'h300, 200, t, cnt, cyc);
    check_run("basic", t, cnt, cyc, 32'd24);
  endtask

  task automatic test_stall();
    bit t; logic [31:0] cnt; int cyc;
    req_delay = 3; wr_delay = 3; rd_delay = 3;
    load_basic(4);
    do_run(32'd4, 32'h100, 32'h200, 32'h300, 500, t, cnt, cyc);
    check_run("stall", t, cnt, cyc, 32'd96);
    req_delay = 0; wr_delay = 0; rd_delay = 0;
  endtask

  task automatic test_overflow();
    bit t; logic [31:0] cnt; int cyc;
    mem_model[64'h1000] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_model[64'h2000] = 64'd2;
    exp_q.push_back({64'h3000, model_sum(64'hFFFF_FFFF_FFFF_FFFF, 64'd2)});
    do_run(32'd1, 32'h1000, 32'h2000, 32'h3000, 50, t, cnt, cyc);
    check_run("overflow", t, cnt, cyc, 32'd6);
  endtask

  task automatic test_reset_midop();
    bit t; logic [31:0] cnt; int cyc, w0;
    logic [255:0] outs;
    load_basic(2);
    w0 = writes_done;
    @(negedge clock);
    length = 32'd4; a_addr = 32'h100; b_addr = 32'h200; c_addr = 32'h300; launch = 1'b1;
    for (int i = 0; i < 100 && writes_done < w0 + 2; i++) @(negedge clock);
    wr_block = 1'b1;
    for (int i = 0; i < 100 && !mem_if.mem_wr_valid; i++) @(negedge clock);
    checks++;
    if (mem_if.mem_wr_valid !== 1'b1 || writes_done != w0 + 2) begin
      failures++;
      $display("[TB] FAIL reach_wr_dat got wr_valid=%b writes=%0d want 1 2",
               mem_if.mem_wr_valid, writes_done - w0);
    end
    @(negedge clock);
    #2 reset = 1'b1; launch = 1'b0;
    #1;
    outs = {finish, event_counter_valid, event_counter_value, mem_if.mem_req_valid,
            mem_if.mem_req_opcode, mem_if.mem_req_len, mem_if.mem_req_addr,
            mem_if.mem_wr_valid, mem_if.mem_wr_bits, mem_if.mem_rd_ready};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("[TB] FAIL midop_reset_outputs got %h want 0", outs);
    end
    @(negedge clock);
    wr_block = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (writes_done != w0 + 2 || mem_if.mem_req_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midop_no_write got writes=%0d req=%b want 2 0",
               writes_done - w0, mem_if.mem_req_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL midop_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    load_basic(4);
    do_run(32'd4, 32'h100, 32'h200, 32'h300, 200, t, cnt, cyc);
    check_run("relaunch", t, cnt, cyc, 32'd24);
  endtask

  task automatic test_launch_hold();
    bit t; logic [31:0] cnt; int cyc, fin0, w0;
    fin0 = finish_pulses; w0 = writes_done;
    load_basic(2);
    do_run(32'd2, 32'h100, 32'h200, 32'h300, 100, t, cnt, cyc);
    check_run("launch_hold", t, cnt, cyc, 32'd12);
    repeat (30) @(negedge clock);
    checks++;
    if (finish_pulses != fin0 + 1 || writes_done != w0 + 2) begin
      failures++;
      $display("[TB] FAIL single_run got pulses=%0d writes=%0d want 1 2",
               finish_pulses - fin0, writes_done - w0);
    end
  endtask

  initial begin : main
    av = '{64'd1, 64'd2, 64'd3, 64'd4};
    bv = '{64'd10, 64'd20, 64'd30, 64'd40};
    sv = '{64'd11, 64'd22, 64'd33, 64'd44};
    test_reset();
    test_zero_length();
    test_basic();
    test_stall();
    test_overflow();
    test_reset_midop();
    test_launch_hold();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
